// File: rtl/zoom_nn_ctrl_pkg.sv
// Shared types and constants for the nearest-neighbour zoom sequencer.
package zoom_nn_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_PASS = 2'b00,
    MODE_ZIN  = 2'b01,
    MODE_ZOUT = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_FLUSH,
    S_DONE
  } state_e;

  localparam int DEF_H_RES = 320;
  localparam int DEF_V_RES = 240;
  localparam int DEF_PIX_W = 8;
  localparam int DEF_FRAME = DEF_H_RES * DEF_V_RES;

  // Multiply by an elaboration-time constant as a sum of shifted terms;
  // with k constant this folds to a few adders (320 -> (v<<8)+(v<<6)).
  function automatic logic [31:0] mul_const(input logic [31:0] v, input int k);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < 31; i++)
      if (k[i]) acc = acc + (v << i);
    return acc;
  endfunction

endpackage

// File: rtl/zoom_nn_ctrl_if.sv
// Frame-memory port bundle: source RAM read side and output memory write side.
interface zoom_nn_ctrl_if #(
  parameter int ADDR_W = 17,
  parameter int PIX_W  = 8
);
  logic [ADDR_W-1:0] src_addr;
  logic              src_rd_en;
  logic [PIX_W-1:0]  src_rdata;
  logic [ADDR_W-1:0] dst_addr;
  logic              dst_we;
  logic [PIX_W-1:0]  dst_wdata;

  modport master (
    output src_addr, src_rd_en, dst_addr, dst_we, dst_wdata,
    input  src_rdata
  );

  modport slave (
    input  src_addr, src_rd_en, dst_addr, dst_we, dst_wdata,
    output src_rdata
  );
endinterface

// File: rtl/zoom_addr_gen.sv
// Combinational map from output coordinate (x,y) to source address and border flag.
module zoom_addr_gen
  import zoom_nn_ctrl_pkg::*;
#(
  parameter int H_RES  = DEF_H_RES,
  parameter int V_RES  = DEF_V_RES,
  parameter int ADDR_W = 17,
  parameter int XW     = $clog2(H_RES),
  parameter int YW     = $clog2(V_RES)
) (
  input  mode_e             mode,
  input  logic [XW-1:0]     x,
  input  logic [YW-1:0]     y,
  output logic [ADDR_W-1:0] src_addr,
  output logic              is_border
);
  localparam int XQ = H_RES / 4;
  localparam int YQ = V_RES / 4;

  logic [XW-1:0] sx;
  logic [YW-1:0] sy;
  logic          in_win;

  assign in_win = (x >= XW'(XQ)) && (x < XW'(3 * XQ)) &&
                  (y >= YW'(YQ)) && (y < YW'(3 * YQ));

  always_comb begin
    sx        = x;
    sy        = y;
    is_border = 1'b0;
    case (mode)
      MODE_ZIN: begin
        sx = XW'(XQ) + (x >> 1);
        sy = YW'(YQ) + (y >> 1);
      end
      MODE_ZOUT: begin
        if (in_win) begin
          sx = (x - XW'(XQ)) << 1;
          sy = (y - YW'(YQ)) << 1;
        end else begin
          sx        = '0;
          sy        = '0;
          is_border = 1'b1;
        end
      end
      default: ;
    endcase
    src_addr = ADDR_W'(mul_const(32'(sy), H_RES) + 32'(sx));
  end

endmodule

// File: rtl/zoom_nn_ctrl.sv
// Raster sequencer: one source read per clock, matching output write one clock later.
module zoom_nn_ctrl
  import zoom_nn_ctrl_pkg::*;
#(
  parameter int              H_RES  = DEF_H_RES,
  parameter int              V_RES  = DEF_V_RES,
  parameter int              ADDR_W = 17,
  parameter int              PIX_W  = DEF_PIX_W,
  parameter logic [PIX_W-1:0] BORDER = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  output logic             busy,
  output logic             done,
  zoom_nn_ctrl_if.master   mem
);
  localparam int XW = $clog2(H_RES);
  localparam int YW = $clog2(V_RES);

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [ADDR_W-1:0] pix_q, pix_d;
  logic [ADDR_W-1:0] hold_q, hold_d;
  logic [ADDR_W-1:0] dst_addr_q, dst_addr_d;
  logic              dst_we_q, dst_we_d;
  logic              border_q, border_d;

  logic [ADDR_W-1:0] gen_addr;
  logic              gen_border;
  logic              scan, last_px;

  zoom_addr_gen #(
    .H_RES(H_RES), .V_RES(V_RES), .ADDR_W(ADDR_W), .XW(XW), .YW(YW)
  ) u_addr_gen (
    .mode(mode_q), .x(x_q), .y(y_q),
    .src_addr(gen_addr), .is_border(gen_border)
  );

  assign scan    = (state_q == S_SCAN);
  assign last_px = (x_q == XW'(H_RES - 1)) && (y_q == YW'(V_RES - 1));

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    x_d        = x_q;
    y_d        = y_q;
    pix_d      = pix_q;
    hold_d     = hold_q;
    dst_addr_d = dst_addr_q;
    border_d   = border_q;
    dst_we_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d  = (mode == MODE_RSVD) ? MODE_PASS : mode_e'(mode);
          x_d     = '0;
          y_d     = '0;
          pix_d   = '0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        dst_we_d   = 1'b1;
        dst_addr_d = pix_q;
        border_d   = gen_border;
        if (!gen_border) hold_d = gen_addr;
        pix_d = pix_q + 1'b1;
        if (x_q == XW'(H_RES - 1)) begin
          x_d = '0;
          y_d = y_q + 1'b1;
        end else begin
          x_d = x_q + 1'b1;
        end
        if (last_px) state_d = S_FLUSH;
      end
      S_FLUSH: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      mode_q     <= MODE_PASS;
      x_q        <= '0;
      y_q        <= '0;
      pix_q      <= '0;
      hold_q     <= '0;
      dst_addr_q <= '0;
      dst_we_q   <= 1'b0;
      border_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      x_q        <= x_d;
      y_q        <= y_d;
      pix_q      <= pix_d;
      hold_q     <= hold_d;
      dst_addr_q <= dst_addr_d;
      dst_we_q   <= dst_we_d;
      border_q   <= border_d;
    end
  end

  assign busy          = scan || (state_q == S_FLUSH);
  assign done          = (state_q == S_DONE);
  // Border pixels skip the read and leave the address bus parked on the last read.
  assign mem.src_rd_en = scan && !gen_border;
  assign mem.src_addr  = mem.src_rd_en ? gen_addr : hold_q;
  assign mem.dst_we    = dst_we_q;
  assign mem.dst_addr  = dst_addr_q;
  assign mem.dst_wdata = !dst_we_q ? '0 : (border_q ? BORDER : mem.src_rdata);

endmodule

// File: tb/tb_zoom_nn_ctrl.sv
// Directed bench for zoom_nn_ctrl on a reduced 20x12 frame; src RAM holds a ramp.
module tb_zoom_nn_ctrl;
  localparam int H  = 20;
  localparam int V  = 12;
  localparam int FR = H * V;
  localparam int AW = 17;
  localparam int PW = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       busy, done;

  zoom_nn_ctrl_if #(.ADDR_W(AW), .PIX_W(PW)) mif ();

  zoom_nn_ctrl #(.H_RES(H), .V_RES(V), .ADDR_W(AW), .PIX_W(PW), .BORDER(8'h00)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .busy(busy), .done(done), .mem(mif)
  );

  always #5 clk = ~clk;

  // source RAM: src[i] = i[7:0], one-cycle read latency
  always @(posedge clk) if (mif.src_rd_en) mif.src_rdata <= mif.src_addr[7:0];

  int n_chk = 0, n_pass = 0;
  int cyc = 0, t0 = 0;
  int done_cnt, done_cyc, first_we, we_cnt, rd_cnt, rd_bad, wa_bad, idle_we, exp_wa;
  logic [1:0] frame_mode;
  logic [7:0] dst_mem [FR];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    else n_pass++;
  endtask

  function automatic void map(input logic [1:0] m, input int n, output bit brd, output int sa);
    int x, y, sx, sy;
    x = n % H; y = n / H; sx = x; sy = y; brd = 0;
    if (m == 2'b01) begin
      sx = H / 4 + x / 2; sy = V / 4 + y / 2;
    end else if (m == 2'b10) begin
      if (x >= H / 4 && x < 3 * H / 4 && y >= V / 4 && y < 3 * V / 4) begin
        sx = (x - H / 4) * 2; sy = (y - V / 4) * 2;
      end else begin
        brd = 1; sx = 0; sy = 0;
      end
    end
    sa = sy * H + sx;
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    bit b; int sa, n;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (mif.src_rd_en) begin
      rd_cnt++;
      n = cyc - t0 - 1;
      map(frame_mode, n, b, sa);
      if (n < 0 || n >= FR || b || int'(mif.src_addr) != sa) rd_bad++;
    end
    if (mif.dst_we) begin
      if (first_we < 0) first_we = cyc;
      if (int'(mif.dst_addr) != exp_wa || exp_wa >= FR) wa_bad++;
      else dst_mem[exp_wa] = mif.dst_wdata;
      exp_wa++; we_cnt++;
      if (!busy) idle_we++;
    end
  end

  task automatic start_frame(input logic [1:0] m);
    done_cnt = 0; done_cyc = -1; first_we = -1; we_cnt = 0; rd_cnt = 0;
    rd_bad = 0; wa_bad = 0; idle_we = 0; exp_wa = 0;
    for (int i = 0; i < FR; i++) dst_mem[i] = 'x;
    @(posedge clk); #1;
    frame_mode = m; mode = m; start = 1'b1; t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int settle);
    int k = 0;
    while (done_cnt == 0 && k < FR + 100) begin @(negedge clk); k++; end
    chk({tag, "_done_seen"}, 32'(done_cnt != 0), 1);
    repeat (settle) @(negedge clk);
  endtask

  task automatic check_frame(input string tag, input logic [1:0] m, input int exp_rd);
    int errs = 0; bit b; int sa;
    for (int i = 0; i < FR; i++) begin
      map(m, i, b, sa);
      if (dst_mem[i] !== (b ? 8'h00 : 8'(sa))) errs++;
    end
    chk({tag, "_data_errs"}, errs, 0);
    chk({tag, "_we_cnt"}, we_cnt, FR);
    chk({tag, "_wa_order"}, wa_bad, 0);
    chk({tag, "_rd_addr"}, rd_bad, 0);
    chk({tag, "_rd_cnt"}, rd_cnt, exp_rd);
    chk({tag, "_done_lat"}, done_cyc - t0, FR + 2);
    chk({tag, "_first_we"}, first_we - t0, 2);
    chk({tag, "_idle_we"}, idle_we, 0);
  endtask

  initial begin
    frame_mode = 2'b00;
    done_cnt = 0; first_we = -1; exp_wa = 0; we_cnt = 0; rd_cnt = 0;
    rd_bad = 0; wa_bad = 0; idle_we = 0; done_cyc = -1;
    repeat (3) @(posedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", mif.src_rd_en, 0);
    chk("rst_we", mif.dst_we, 0);
    chk("rst_src_addr", mif.src_addr, 0);
    chk("rst_dst_addr", mif.dst_addr, 0);
    chk("rst_wdata", mif.dst_wdata, 0);
    reset = 1'b0;

    start_frame(2'b00);
    wait_done("pass", 5);
    check_frame("pass", 2'b00, FR);
    chk("pass_single_done", done_cnt, 1);

    start_frame(2'b01);
    wait_done("zin", 5);
    check_frame("zin", 2'b01, FR);
    chk("zin_d0", dst_mem[0], 65);
    chk("zin_d1", dst_mem[1], 65);
    chk("zin_d20", dst_mem[20], 65);
    chk("zin_d21", dst_mem[21], 65);
    chk("zin_d2", dst_mem[2], 66);
    chk("zin_dlast", dst_mem[FR-1], 174);

    // back-to-back: the next start lands in the cycle right after done
    start_frame(2'b10);
    wait_done("zout", 0);
    check_frame("zout", 2'b10, (H / 2) * (V / 2));
    chk("zout_d0", dst_mem[0], 0);
    chk("zout_d64", dst_mem[64], 0);
    chk("zout_d65", dst_mem[65], 0);
    chk("zout_d66", dst_mem[66], 2);
    chk("zout_d85", dst_mem[85], 40);
    chk("zout_d75", dst_mem[75], 0);
    chk("zout_d194", dst_mem[194], 0);

    start_frame(2'b11);
    wait_done("rsvd", 5);
    check_frame("rsvd", 2'b00, FR);

    // restart attempt and mode churn mid-frame must be ignored
    start_frame(2'b00);
    while (cyc < t0 + 50) @(posedge clk);
    #1 start = 1'b1; mode = 2'b01;
    @(posedge clk); #1 start = 1'b0; mode = 2'b10;
    wait_done("ign", 5);
    check_frame("ign", 2'b00, FR);
    chk("ign_single_done", done_cnt, 1);

    start_frame(2'b01);
    while (cyc < t0 + 100) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_we", mif.dst_we, 0);
    chk("mid_rst_rd_en", mif.src_rd_en, 0);
    repeat (FR + 10) @(negedge clk);
    chk("mid_rst_no_done", done_cnt, 0);

    start_frame(2'b10);
    wait_done("post_rst", 5);
    check_frame("post_rst", 2'b10, (H / 2) * (V / 2));
    chk("post_rst_single_done", done_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
